rr_sel_arbiter: RTL

Four-way round-robin arbiter that produces the registered 2-bit index and grant-valid flag consumed by the 2-to-4 decoder stage. The decoder turns the index into a one-hot select, and `gnt_valid` drives its enable. The block holds each grant until the owner releases it or a hold limit expires. It guarantees one idle cycle between grants so the downstream one-hot never switches directly between two owners.

---
 rtl/rr_sel_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: four-way round-robin arbiter feeding the 2-to-4 select decoder.
// A grant is held until the owner signals done, drops its request, or the hold
// limit expires. At least one idle cycle separates consecutive grants, so the
// downstream one-hot select never moves directly from one owner to another.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | no owner; search req from r_ptr and grant on the next edge
// ST_GRANT | o_gnt_idx owns the resource; watch done / req drop / hold limit
module rr_sel_arbiter #(
  parameter int HOLD_W   = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  input  logic       i_done,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // HOLD_MAX = 0 disables the limit; the compare value is then never used.
  localparam bit                LP_LIMITED   = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_gnt_idx;
  logic              r_gnt_valid;
  logic              r_timeout;

  state_t            w_state_nxt;
  logic [1:0]        w_ptr_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic [1:0]        w_gnt_idx_nxt;
  logic              w_gnt_valid_nxt;
  logic              w_timeout_nxt;

  logic              w_found;
  logic [1:0]        w_pick;
  logic [1:0]        w_cand;
  logic              w_owner_req;
  logic              w_hold_hit;
  logic              w_release;

  // Round-robin search: first set request at r_ptr, r_ptr+1, ... modulo 4.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Release conditions; done and a request drop outrank the hold limit.
  always_comb begin
    w_owner_req = i_req[r_gnt_idx];
    w_hold_hit  = LP_LIMITED && (r_hold_cnt == LP_HOLD_LAST);
    w_release   = i_done || !w_owner_req || w_hold_hit;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_valid_nxt = 1'b0;
        if (w_found) begin
          w_gnt_idx_nxt   = w_pick;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = '0;
          w_state_nxt     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_gnt_idx + 2'd1;
          w_state_nxt     = ST_IDLE;
          // Forced only when neither normal release cause is present.
          w_timeout_nxt   = !i_done && w_owner_req;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_hold_cnt  <= '0;
      r_gnt_idx   <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule
